// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq -- multi-cycle restoring divider (quotient + remainder)
//
// Resolves one quotient bit per clock. One operation is in flight at a time.
//
// Handshake: start is sampled only while the block is idle (busy=0). When it
// is accepted, A, B and is_signed are captured and later changes on them have
// no effect. busy stays high from acceptance until the controller is back in
// IDLE. A request made while busy=1 is dropped, not queued. done is a
// one-cycle pulse that marks Q/R/div_by_zero as freshly updated. Those
// outputs then hold until the next done. To run operations back to back,
// hold start or raise it again once busy=0.
//
// Optional feature macro: DIVIDER_SEQ_SIGNED_EN
//   defined   : is_signed=1 selects two's-complement operands. The datapath
//               divides magnitudes and applies the sign fix-up while loading
//               the result. The quotient truncates toward zero and the
//               remainder takes the dividend's sign.
//   undefined : is_signed is ignored and no sign logic is built.
//
// Parameters:
//   WIDTH  operand/result width (2..32)
//   CNT_W  iteration counter width (derived)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   operation request, sampled in IDLE only
//   is_signed    in   two's-complement select, sampled with start
//   A            in   dividend, sampled with start
//   B            in   divisor, sampled with start
//   busy         out  operation in progress (CALC or DONE)
//   done         out  one-cycle pulse, results valid
//   Q            out  quotient (registered)
//   R            out  remainder (registered)
//   div_by_zero  out  set with done when B was zero
// ---------------------------------------------------------------------------
module divider_seq #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d;   // partial remainder, one guard bit
   logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0]   dvs_q, dvs_d;   // latched divisor magnitude
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               dbz_q, dbz_d;
   logic               done_q, done_d;

   // One restoring step: shift {rem, dividend} left, subtract when it fits.
   logic [WIDTH:0]     shifted;
   logic               fits;
   logic [WIDTH:0]     rem_next;
   logic [WIDTH-1:0]   quo_next;

   // Operand magnitudes and sign-corrected results.
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign shifted  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
   assign fits     = (shifted >= {1'b0, dvs_q});
   assign rem_next = fits ? (shifted - {1'b0, dvs_q}) : shifted;
   assign quo_next = {dvd_q[WIDTH-2:0], fits};

   // The remainder is always below the divisor, so the guard bit of the
   // stored remainder is zero whenever it is shifted.
   logic unused_rem_msb;
   assign unused_rem_msb = rem_q[WIDTH];

`ifdef DIVIDER_SEQ_SIGNED_EN
   logic a_neg, b_neg;
   logic qneg_q, rneg_q;

   assign a_neg = is_signed & A[WIDTH-1];
   assign b_neg = is_signed & B[WIDTH-1];
   // The magnitude of the most-negative value is itself when read as
   // unsigned, so most-negative / -1 wraps back to most-negative on its own.
   assign a_mag = a_neg ? (~A + WIDTH'(1)) : A;
   assign b_mag = b_neg ? (~B + WIDTH'(1)) : B;
   assign q_fix = qneg_q ? (~quo_next + WIDTH'(1)) : quo_next;
   assign r_fix = rneg_q ? (~rem_next[WIDTH-1:0] + WIDTH'(1)) : rem_next[WIDTH-1:0];

   // Signs are captured together with the operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else if ((state_q == S_IDLE) && start && (B != '0)) begin
         qneg_q <= a_neg ^ b_neg;
         rneg_q <= a_neg;
      end
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;
   assign a_mag = A;
   assign b_mag = B;
   assign q_fix = quo_next;
   assign r_fix = rem_next[WIDTH-1:0];
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      // The done pulse is the registered image of the DONE state. Results are
      // already loaded when it rises, and the controller is back in IDLE
      // during the pulse.
      done_d  = (state_q == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (B == '0) begin
                  quo_d   = '0;
                  res_d   = A;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  dvd_d   = a_mag;
                  dvs_d   = b_mag;
                  rem_d   = '0;
                  cnt_d   = CNT_W'(WIDTH);
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            rem_d = rem_next;
            dvd_d = quo_next;
            cnt_d = cnt_q - CNT_W'(1);
            // The last iteration loads the outputs directly from the step
            // logic, so the counter reaches zero on the same edge.
            if (cnt_q == CNT_W'(1)) begin
               quo_d   = q_fix;
               res_d   = r_fix;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign Q           = quo_q;
   assign R           = res_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_divider_seq -- directed self-checking bench for divider_seq (WIDTH=8)
// ---------------------------------------------------------------------------
module tb_divider_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         div_by_zero;

   int n_chk  = 0;
   int n_pass = 0;

   divider_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
   endtask

   // Launch one operation and follow it to its done pulse. Latency is counted
   // in clock edges after the edge that samples start.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat);
      int  k;
      bit  seen;
      logic busy_first;
      @(negedge clk);
      A = a; B = b; is_signed = sgn; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Operands are captured; scramble the inputs to prove it.
      A = W'($urandom_range(0, 255));
      B = W'($urandom_range(0, 255));
      is_signed = ~sgn;
      k = 0;
      seen = 1'b0;
      busy_first = 1'b0;
      while (!seen && k <= elat + 20) begin
         @(negedge clk);
         if (k == 0) busy_first = busy;
         if (done) seen = 1'b1;
         else k++;
      end
      check({tag, " busy_after_start"}, busy_first, 1);
      check({tag, " latency"}, k, elat);
      check({tag, " Q"}, Q, eq);
      check({tag, " R"}, R, er);
      check({tag, " div_by_zero"}, div_by_zero, edbz);
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " busy_released"}, busy, 0);
      is_signed = 1'b0;
   endtask

   initial begin
      int dones;
      int first_done;
      logic [W-1:0] q_seen, r_seen;

      rst_n = 1'b0;
      start = 1'b0;
      is_signed = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset Q", Q, 0);
      check("reset R", R, 0);
      check("reset div_by_zero", div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Main function and boundaries
      do_op("200/7",   8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 9);
      do_op("5/0",     8'd5,   8'd0,   1'b0, 8'd0,   8'd5,   1'b1, 1);
      do_op("9/3",     8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0, 9);
      do_op("255/1",   8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 9);
      do_op("3/250",   8'd3,   8'd250, 1'b0, 8'd0,   8'd3,   1'b0, 9);
      do_op("0/9",     8'd0,   8'd9,   1'b0, 8'd0,   8'd0,   1'b0, 9);
      do_op("255/255", 8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 9);
      do_op("254/255", 8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0, 9);
      do_op("0/0",     8'd0,   8'd0,   1'b0, 8'd0,   8'd0,   1'b1, 1);

      // Start pulses and operand changes while busy are ignored
      @(negedge clk);
      A = 8'd100; B = 8'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dones = 0;
      first_done = -1;
      q_seen = '0;
      r_seen = '0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (first_done < 0) begin
               first_done = c;
               q_seen = Q;
               r_seen = R;
            end
         end
         if (c >= 1 && c <= 3) begin
            start = 1'b1; A = 8'd50; B = 8'd3;
         end else begin
            start = 1'b0;
         end
      end
      check("busy_ignore done_count", dones, 1);
      check("busy_ignore latency", first_done, 9);
      check("busy_ignore Q", q_seen, 11);
      check("busy_ignore R", r_seen, 1);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      A = 8'd200; B = 8'd13; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset Q", Q, 0);
      check("midreset R", R, 0);
      check("midreset div_by_zero", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midreset no_done", dones, 0);
      do_op("77/7 after reset", 8'd77, 8'd7, 1'b0, 8'd11, 8'd0, 1'b0, 9);

      // Signed mode (unsigned results when the feature is not built)
      do_op("u 249/2", 8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, 9);
      do_op("s -5/0",  8'hFB, 8'h00, 1'b1, 8'h00, 8'hFB, 1'b1, 1);
`ifdef DIVIDER_SEQ_SIGNED_EN
      do_op("s -7/2",    8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9);
      do_op("s -128/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9);
      do_op("s 7/-2",    8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9);
      do_op("s -9/-4",   8'hF7, 8'hFC, 1'b1, 8'h02, 8'hFF, 1'b0, 9);
`else
      do_op("s -7/2",    8'hF9, 8'h02, 1'b1, 8'd124, 8'd1,   1'b0, 9);
      do_op("s -128/-1", 8'h80, 8'hFF, 1'b1, 8'd0,   8'd128, 1'b0, 9);
      do_op("s 7/-2",    8'h07, 8'hFE, 1'b1, 8'd0,   8'd7,   1'b0, 9);
      do_op("s -9/-4",   8'hF7, 8'hFC, 1'b1, 8'd0,   8'hF7,  1'b0, 9);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Parametrised, multi-cycle restoring divider; successor to the combinational 4-bit divider in the calculator datapath.
- Produces both quotient and remainder after a start/done handshake.
- Flags divide-by-zero explicitly instead of silently returning 0.
- Feeds the BCD display path. One operation in flight at a time; one quotient bit resolved per clock.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 2..32)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  two's-complement mode select (see Optional Feature); sampled with start
- A  input  WIDTH  dividend; sampled with start
- B  input  WIDTH  divisor; sampled with start
- busy  output  1  high while an operation is in progress (CALC or DONE)
- done  output  1  one-cycle pulse: Q/R/div_by_zero valid and updated
- Q  output  WIDTH  quotient, registered, held until next done
- R  output  WIDTH  remainder, registered, held until next done
- div_by_zero  output  1  registered; set with done when B==0, cleared with next done

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; internal regs cleared.
- Reset mid-operation aborts immediately; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE, start=1, B!=0: latch A, B and is_signed; partial remainder=0; counter=WIDTH; go to CALC.
- IDLE, start=1, B==0: go straight to DONE with Q=0, R=A, div_by_zero=1.
- IDLE, start=0: remain in IDLE.
- CALC, each cycle: shift {rem, dividend} left 1; if rem >= divisor, subtract and shift in quotient bit 1, else shift in 0; counter decrements.
- CALC exit: leave on the cycle counter reaches 0, after exactly WIDTH iterations. Q/R/div_by_zero outputs load at this transition.
- DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
- busy=1 in CALC and DONE; 0 in IDLE.
- Latency, nonzero divisor: start sampled at edge 0; done high in the cycle following edge WIDTH+1. Next start can be accepted at edge WIDTH+2.
- Latency, zero divisor: done high in the cycle following edge 1.
- start while busy=1 is ignored. A/B changes during busy have no effect.
- start asserted in the DONE cycle is ignored. Back-to-back operations therefore need start held or re-asserted once busy=0.
- Unsigned arithmetic: Q=floor(A/B), R=A-Q*B, with R<B always. No overflow is possible.
- Internal remainder register is WIDTH+1 bits to hold the pre-subtract value.

Optional Feature:
- Macro: DIVIDER_SEQ_SIGNED_EN.
- Defined, is_signed=1:
  - Operands are two's complement; the divider runs on magnitudes.
  - Quotient is negated when the operand signs differ, so it truncates toward zero.
  - Remainder takes the dividend's sign.
  - Sign fix-up is applied in the CALC->DONE load, so latency is unchanged.
  - Special case: most-negative / -1 yields Q = most-negative, R = 0 (wrap, no flag).
  - Divide-by-zero still gives Q=0, R=A.
- Defined, is_signed=0: unsigned behaviour.
- Undefined: is_signed is ignored; always unsigned, and no sign logic is synthesised.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 mid-CALC -> busy, done, Q, R, div_by_zero all 0 immediately; no done follows release.
- A=200, B=7, start 1 cycle -> done exactly 9 cycles after the start edge; Q=28, R=4, div_by_zero=0; busy high 9 cycles.
- A=5, B=0 -> done 1 cycle after start; Q=0, R=5, div_by_zero=1; next op A=9, B=3 -> Q=3, R=0, div_by_zero=0.
- Boundaries: A=255, B=1 -> Q=255, R=0; A=3, B=250 -> Q=0, R=3; A=0, B=9 -> Q=0, R=0.
- start pulsed and A/B changed during busy -> ignored; results match the first operands; exactly one done pulse.
- DIVIDER_SEQ_SIGNED_EN, is_signed=1:
  - A=-7 (0xF9), B=2 -> Q=-3 (0xFD), R=-1 (0xFF).
  - A=-128, B=-1 -> Q=0x80, R=0.
  - Same stimulus with the macro undefined -> unsigned results (249/2 -> Q=124, R=1).
